// File: rtl/core_pipe_exec_mdu_seq.sv
// Issue/writeback sequencer around the execute-stage multiply/divide unit.
// Holds one M-extension op stable to the MDU and presents its result to writeback.
module core_pipe_exec_mdu_seq #(
    parameter bit          BYPASS_DIVZERO = 1'b1,
    parameter int unsigned XLEN           = 64
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_op_word,
    input  logic [7:0]      s_op,
    input  logic [XLEN-1:0] s_rs1,
    input  logic [XLEN-1:0] s_rs2,
    input  logic [4:0]      s_rd_addr,
    output logic            mdu_flush,
    output logic            mdu_valid,
    output logic            mdu_op_word,
    output logic [7:0]      mdu_op,
    output logic [XLEN-1:0] mdu_rs1,
    output logic [XLEN-1:0] mdu_rs2,
    input  logic            mdu_ready,
    input  logic [XLEN-1:0] mdu_rd,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd_addr,
    output logic [XLEN-1:0] wb_data
);

    typedef enum logic [1:0] {StIdle, StRun, StResult} state_e;

    state_e          state_q, state_d;
    logic            word_q, word_d;
    logic [7:0]      op_q, op_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            accept;
    logic            is_div;
    logic            rs2_zero;
    logic            local_res;
    logic [XLEN-1:0] local_data;
    state_e          issue_state;

    // Divide-by-zero and empty ops resolve without ever waking the MDU.
    assign is_div      = |s_op[7:4];
    assign rs2_zero    = s_op_word ? (s_rs2[31:0] == 32'd0) : (s_rs2 == '0);
    assign local_res   = (s_op == 8'd0) || (is_div && rs2_zero && BYPASS_DIVZERO);
    assign issue_state = local_res ? StResult : StRun;
    assign accept      = s_valid && s_ready;

    always_comb begin
        local_data = s_rs1;
        if (s_op == 8'd0) begin
            local_data = '0;
        end else if (s_op[4] || s_op[5]) begin
            local_data = '1;
        end else if (s_op_word) begin
            local_data = {{(XLEN-32){s_rs1[31]}}, s_rs1[31:0]};
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (accept) state_d = issue_state;
                StRun:    if (mdu_ready) state_d = StResult;
                StResult: if (wb_ready) state_d = accept ? issue_state : StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        s_ready   = !flush && ((state_q == StIdle) || ((state_q == StResult) && wb_ready));
        mdu_valid = (state_q == StRun);
        mdu_flush = flush || (state_q != StRun);
        wb_valid  = (state_q == StResult);
    end

    always_comb begin
        word_d    = word_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        if (accept) begin
            word_d = s_op_word;
            op_d   = s_op;
            rs1_d  = s_rs1;
            rs2_d  = s_rs2;
            rd_d   = s_rd_addr;
            if (local_res) wb_data_d = local_data;
        end else if ((state_q == StRun) && mdu_ready && !flush) begin
            wb_data_d = mdu_rd;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            word_q    <= 1'b0;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
        end else begin
            word_q    <= word_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign mdu_op_word = word_q;
    assign mdu_op      = op_q;
    assign mdu_rs1     = rs1_q;
    assign mdu_rs2     = rs2_q;
    assign wb_rd_addr  = rd_q;
    assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_core_pipe_exec_mdu_seq.sv
// Scoreboard bench for core_pipe_exec_mdu_seq with a fixed-latency behavioural MDU.
module tb_core_pipe_exec_mdu_seq;

    localparam int Lat = 5;

    logic        g_clk = 1'b0;
    logic        g_resetn, flush, s_valid, s_ready, s_op_word;
    logic [7:0]  s_op;
    logic [63:0] s_rs1, s_rs2;
    logic [4:0]  s_rd_addr;
    logic        mdu_flush, mdu_valid, mdu_op_word, mdu_ready;
    logic [7:0]  mdu_op;
    logic [63:0] mdu_rs1, mdu_rs2, mdu_rd;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_data;

    always #5 g_clk = ~g_clk;

    core_pipe_exec_mdu_seq dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_op_word(s_op_word), .s_op(s_op),
        .s_rs1(s_rs1), .s_rs2(s_rs2), .s_rd_addr(s_rd_addr),
        .mdu_flush(mdu_flush), .mdu_valid(mdu_valid), .mdu_op_word(mdu_op_word),
        .mdu_op(mdu_op), .mdu_rs1(mdu_rs1), .mdu_rs2(mdu_rs2),
        .mdu_ready(mdu_ready), .mdu_rd(mdu_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   mdu_windows = 0;
    logic mdu_valid_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] mdu_calc(input logic [7:0] op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  r32;
        logic [63:0]  r;
        r = '0;
        p = '0;
        r32 = '0;
        if (w) begin
            case (op)
                8'h01:   r32 = a[31:0] * b[31:0];
                8'h10:   r32 = $signed(a[31:0]) / $signed(b[31:0]);
                8'h20:   r32 = a[31:0] / b[31:0];
                8'h40:   r32 = $signed(a[31:0]) % $signed(b[31:0]);
                8'h80:   r32 = a[31:0] % b[31:0];
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (op)
                8'h01: r = a * b;
                8'h02: begin
                    p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                    r = p[127:64];
                end
                8'h04: begin
                    p = {64'd0, a} * {64'd0, b};
                    r = p[127:64];
                end
                8'h08: begin
                    p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
                    r = p[127:64];
                end
                8'h10:   r = $signed(a) / $signed(b);
                8'h20:   r = a / b;
                8'h40:   r = $signed(a) % $signed(b);
                8'h80:   r = a % b;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Behavioural MDU: answers Lat cycles after valid rises, cleared by mdu_flush.
    int mdu_cnt = 0;
    always @(posedge g_clk) begin
        if (mdu_flush) begin
            mdu_cnt   <= 0;
            mdu_ready <= 1'b0;
        end else if (mdu_valid) begin
            mdu_cnt   <= mdu_cnt + 1;
            mdu_ready <= (mdu_cnt == Lat - 1);
            mdu_rd    <= mdu_calc(mdu_op, mdu_op_word, mdu_rs1, mdu_rs2);
        end
    end

    always @(negedge g_clk) begin
        if (mdu_valid && !mdu_valid_prev) mdu_windows++;
        mdu_valid_prev = mdu_valid;
    end

    // Monitor: every presented result must match the scoreboard head.
    always @(negedge g_clk) begin
        if (g_resetn && wb_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_wb: got rd %0d data %h expected no result",
                         wb_rd_addr, wb_data);
            end else begin
                check("wb_data", wb_data, exp_q[0].data);
                check("wb_rd_addr", {59'd0, wb_rd_addr}, {59'd0, exp_q[0].rd});
                if (wb_ready && !flush) void'(exp_q.pop_front());
            end
        end
    end

    task automatic expect_wb(input logic [4:0] rd, input logic [63:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [7:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, output logic acc_wb);
        int   n;
        logic acc;
        n      = 0;
        acc    = 1'b0;
        acc_wb = 1'b0;
        s_op = op; s_op_word = w; s_rs1 = a; s_rs2 = b; s_rd_addr = rd; s_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge g_clk);
            acc    = s_ready;
            acc_wb = wb_valid;
            @(posedge g_clk);
            n++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got s_ready 0 expected 1 within 100 cycles");
        end
        #1 s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge g_clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic acc_wb, acc_wb2;
        int   n;
        g_resetn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_op_word = 1'b0; s_op = '0;
        s_rs1 = '0; s_rs2 = '0; s_rd_addr = '0; wb_ready = 1'b1;
        mdu_ready = 1'b0; mdu_rd = '0;
        repeat (3) @(posedge g_clk);
        #1 g_resetn = 1'b1;
        @(negedge g_clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_mdu_valid", mdu_valid, 0);
        check("rst_mdu_flush", mdu_flush, 1);
        check("rst_wb_data", wb_data, 0);
        check("rst_mdu_rs1", mdu_rs1, 0);
        @(posedge g_clk);
        #1;

        // MUL 3 * -5
        expect_wb(5'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        issue(8'h01, 1'b0, 64'd3, -64'sd5, 5'd5, acc_wb);
        drain();

        // DIVU by zero: bypass, result one cycle after accept
        expect_wb(5'd6, '1);
        issue(8'h20, 1'b0, 64'd7, 64'd0, 5'd6, acc_wb);
        @(negedge g_clk);
        check("divu0_latency", wb_valid, 1);
        check("divu0_mdu_idle", mdu_valid, 0);
        drain();

        // REMW by zero (upper rs2 bits ignored for *W)
        expect_wb(5'd7, 64'hFFFF_FFFF_8000_0000);
        issue(8'h40, 1'b1, 64'h0000_0000_8000_0000, 64'hABCD_0000_0000_0000, 5'd7, acc_wb);
        @(negedge g_clk);
        check("remw0_latency", wb_valid, 1);
        drain();

        // DIV -20 / 3 with writeback stalled
        wb_ready = 1'b0;
        expect_wb(5'd8, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(8'h10, 1'b0, -64'sd20, 64'd3, 5'd8, acc_wb);
        n = 0;
        while (!wb_valid && n < 50) begin
            @(negedge g_clk);
            n++;
        end
        repeat (5) @(posedge g_clk);
        #1 wb_ready = 1'b1;
        drain();
        @(negedge g_clk);
        check("div_idle_ready", s_ready, 1);
        check("div_idle_wb", wb_valid, 0);
        @(posedge g_clk);
        #1;

        // MULHU killed by flush mid-RUN
        issue(8'h04, 1'b0, '1, '1, 5'd9, acc_wb);
        repeat (3) @(posedge g_clk);
        #1 flush = 1'b1;
        @(posedge g_clk);
        #1 flush = 1'b0;
        @(negedge g_clk);
        check("flush_wb_valid", wb_valid, 0);
        check("flush_mdu_valid", mdu_valid, 0);
        repeat (10) @(posedge g_clk);
        #1;
        expect_wb(5'd10, 64'd14);
        issue(8'h20, 1'b0, 64'd100, 64'd7, 5'd10, acc_wb);
        drain();

        // Back-to-back MULs: second accepted while first is in RESULT
        expect_wb(5'd11, 64'd42);
        expect_wb(5'd12, 64'h0000_0003_0000_0000);
        issue(8'h01, 1'b0, 64'd6, 64'd7, 5'd11, acc_wb);
        issue(8'h01, 1'b0, 64'h0000_0001_0000_0000, 64'd3, 5'd12, acc_wb2);
        check("b2b_accept_in_result", acc_wb2, 1);
        drain();

        // Empty opcode resolves locally to zero
        expect_wb(5'd13, 64'd0);
        issue(8'h00, 1'b0, 64'd5, 64'd5, 5'd13, acc_wb);
        @(negedge g_clk);
        check("noop_latency", wb_valid, 1);
        drain();

        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        check("mdu_windows", mdu_windows, 6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
